ms_timer_scheduler: RTL and testbench
=====================================

Name: ms_timer_scheduler

Overview:
- Shares one 100 MHz→1 ms prescaler between NUM_CH independent countdown channels.
- Requesters (display refresh, UART timeout, game/step logic) arm a channel with a duration in milliseconds. The block sequences the countdowns and reports expiry.
- Replaces per-module free-running dividers with single-cycle enable strobes in the clk domain. No derived clocks are produced.

Parameters:
- MS_DIV, 100000, clk cycles per ms_tick (100 MHz → 1 kHz).
- NUM_CH, 4, number of countdown channels (2..8).
- CNT_W, 16, width of duration/count per channel, in ms.
- CH_W, 2, width of the channel index; equals clog2(NUM_CH).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  single-cycle write strobe; arms channel cfg_ch.
- cfg_cancel  in  1  single-cycle strobe; cancels channel cfg_ch.
- cfg_ch  in  CH_W  target channel for cfg_we/cfg_cancel.
- cfg_ms  in  CNT_W  duration in ms.
- cfg_periodic  in  1  reload mode for the armed channel (present only with the macro).
- irq_clr  in  NUM_CH  per-channel sticky-flag clear.
- ms_tick  out  1  one-cycle pulse every MS_DIV cycles.
- busy  out  NUM_CH  channel running.
- expired  out  NUM_CH  one-cycle pulse on expiry.
- irq  out  NUM_CH  sticky expiry flag.

Behaviour:
- Reset (async, asserts immediately):
  - Prescaler, all counts, busy, expired, irq and the periodic bits → 0.
  - ms_tick → 0.
  - First ms_tick occurs MS_DIV cycles after rst deasserts.
- Prescaler:
  - Counter runs 0..MS_DIV-1.
  - ms_tick is registered and high for the one cycle after the counter wraps. Period is exactly MS_DIV cycles.
  - The prescaler is never reset by cfg traffic.
- Per-channel state machine, IDLE / RUN:
  - IDLE + cfg_we (cfg_ms≥1): count←cfg_ms, RUN, busy=1 from the next cycle.
  - IDLE + cfg_we with cfg_ms=0: no RUN. expired and irq pulse/set on the next cycle. busy stays 0.
  - RUN + ms_tick: count←count-1.
  - RUN + ms_tick with count=1: count←0, expired pulses next cycle, irq set, →IDLE.
  - RUN + cfg_we: restart with the new cfg_ms. No expiry for the old run.
  - RUN + cfg_cancel: →IDLE, count←0. No expired pulse, irq unchanged.
- Expiry latency after arming with N: between (N-1)·MS_DIV+1 and N·MS_DIV cycles, depending on prescaler phase.
- Simultaneous events:
  - cfg_we and ms_tick on the same channel, same cycle: the write wins and the tick is ignored for that channel.
  - cfg_we and cfg_cancel together: cfg_we wins.
  - Expiry and irq_clr on the same channel, same cycle: set wins.
- Channels are fully independent. Multiple channels may expire on the same tick, each pulsing expired in the same cycle.
- cfg_ch ≥ NUM_CH: write/cancel ignored.
- All outputs are registered.

Optional Feature:
- Macro: MS_TIMER_SCHED_PERIODIC_EN.
- Defined:
  - cfg_periodic port exists and is latched per channel on cfg_we.
  - On expiry a periodic channel reloads count←latched duration and stays RUN with busy=1. The interval between expired pulses is exactly duration·MS_DIV cycles.
  - cfg_cancel stops the channel.
  - Periodic with cfg_ms=0 is treated as one-shot with cfg_ms=0.
- Undefined: port absent; all channels are one-shot.

Decomposition:
- Package ms_timer_pkg holds:
  - Default constants CLK_HZ=100_000_000 and MS_DIV=CLK_HZ/1000.
  - State enum {IDLE, RUN}.
- One natural sub-module, ms_timer_channel: holds a single channel's count, state and irq. It is instantiated NUM_CH times via generate.
- The prescaler stays in the top.

Test Plan (MS_DIV=10 for simulation):
- Reset then idle: ms_tick pulses at cycles 10, 20, 30 after rst release; busy/expired/irq stay 0.
- Arm ch0 with 3 immediately after a tick: expired[0] pulses once, 30±1 cycles later. busy[0] falls in the same cycle. irq[0] stays 1 until irq_clr[0].
- Arm ch1=5, ch2=5 on consecutive cycles: both expire on the same tick boundary. Cancel ch3 mid-run: no pulse, busy[3]→0 next cycle.
- cfg_we on ch0 with value 4 in the exact cycle of ms_tick while ch0 count=1: no expiry; new run expires after 4 further ticks. cfg_ms=0 gives an expired pulse on the next cycle.
- Assert rst asynchronously mid-run (between clk edges): all outputs 0 before the next edge; no expired pulse after release.
- With MS_TIMER_SCHED_PERIODIC_EN, arm ch0 periodic=1, cfg_ms=2: expired[0] every 20 cycles for ≥5 periods. cfg_cancel stops it. Without the macro, the same stimulus gives a single pulse.

Source files
------------

// File: rtl/ms_timer_pkg.sv
// ms_timer_pkg: shared constants and channel state encoding for ms_timer_scheduler.
// Revision: 1.0
`default_nettype none

package ms_timer_pkg;

    localparam int CLK_HZ = 100_000_000;
    localparam int MS_DIV = CLK_HZ / 1000;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ms_timer_channel.sv
// ms_timer_channel: one millisecond countdown channel (count, IDLE/RUN state, sticky irq).
// Optional reload mode under MS_TIMER_SCHED_PERIODIC_EN. Revision: 1.0
`default_nettype none

module ms_timer_channel
    import ms_timer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             cancel,
    input  logic [CNT_W-1:0] ms,
`ifdef MS_TIMER_SCHED_PERIODIC_EN
    input  logic             periodic,
`endif
    input  logic             tick,
    input  logic             irq_clr,
    output logic             busy,
    output logic             expired,
    output logic             irq
);

    state_t           state, state_n;
    logic [CNT_W-1:0] count, count_n;
    logic             expire_n;
    logic             irq_n;
`ifdef MS_TIMER_SCHED_PERIODIC_EN
    logic             periodic_q, periodic_n;
    logic [CNT_W-1:0] reload, reload_n;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            expired    <= 1'b0;
            irq        <= 1'b0;
`ifdef MS_TIMER_SCHED_PERIODIC_EN
            periodic_q <= 1'b0;
            reload     <= '0;
`endif
        end else begin
            state      <= state_n;
            count      <= count_n;
            expired    <= expire_n;
            irq        <= irq_n;
`ifdef MS_TIMER_SCHED_PERIODIC_EN
            periodic_q <= periodic_n;
            reload     <= reload_n;
`endif
        end
    end

    // Priority: write, then cancel, then tick; a write in a tick cycle discards that tick.
    always_comb begin
        state_n  = state;
        count_n  = count;
        expire_n = 1'b0;
        irq_n    = irq;
`ifdef MS_TIMER_SCHED_PERIODIC_EN
        periodic_n = periodic_q;
        reload_n   = reload;
`endif
        if (we) begin
            if (ms == '0) begin
                state_n  = IDLE;
                count_n  = '0;
                expire_n = 1'b1;
`ifdef MS_TIMER_SCHED_PERIODIC_EN
                periodic_n = 1'b0;
`endif
            end else begin
                state_n = RUN;
                count_n = ms;
`ifdef MS_TIMER_SCHED_PERIODIC_EN
                periodic_n = periodic;
                reload_n   = ms;
`endif
            end
        end else if (cancel) begin
            state_n = IDLE;
            count_n = '0;
        end else if (state == RUN && tick) begin
            if (count == CNT_W'(1)) begin
                expire_n = 1'b1;
`ifdef MS_TIMER_SCHED_PERIODIC_EN
                if (periodic_q) begin
                    count_n = reload;
                end else begin
                    state_n = IDLE;
                    count_n = '0;
                end
`else
                state_n = IDLE;
                count_n = '0;
`endif
            end else begin
                count_n = count - 1'b1;
            end
        end

        if (expire_n) begin
            irq_n = 1'b1;
        end else if (irq_clr) begin
            irq_n = 1'b0;
        end
    end

    assign busy = (state == RUN);

endmodule

`default_nettype wire

// File: rtl/ms_timer_scheduler.sv
// ms_timer_scheduler: one shared 1 ms prescaler driving NUM_CH countdown channels.
// Optional periodic reload under MS_TIMER_SCHED_PERIODIC_EN. Revision: 1.0
`default_nettype none

module ms_timer_scheduler #(
    parameter int MS_DIV = ms_timer_pkg::MS_DIV,
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int CH_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic              cfg_cancel,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_ms,
`ifdef MS_TIMER_SCHED_PERIODIC_EN
    input  logic              cfg_periodic,
`endif
    input  logic [NUM_CH-1:0] irq_clr,
    output logic              ms_tick,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] expired,
    output logic [NUM_CH-1:0] irq
);

    import ms_timer_pkg::*;

    localparam int PRE_W = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

    logic [PRE_W-1:0] pre_cnt;

    // Tick is registered off the wrap so it lands exactly MS_DIV cycles apart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            ms_tick <= 1'b0;
        end else if (pre_cnt == PRE_W'(MS_DIV - 1)) begin
            pre_cnt <= '0;
            ms_tick <= 1'b1;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
            ms_tick <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = (cfg_ch == CH_W'(i));

        ms_timer_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .we       (cfg_we & sel),
            .cancel   (cfg_cancel & sel),
            .ms       (cfg_ms),
`ifdef MS_TIMER_SCHED_PERIODIC_EN
            .periodic (cfg_periodic),
`endif
            .tick     (ms_tick),
            .irq_clr  (irq_clr[i]),
            .busy     (busy[i]),
            .expired  (expired[i]),
            .irq      (irq[i])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_ms_timer_scheduler.sv
// tb_ms_timer_scheduler: directed, table-driven bench for ms_timer_scheduler with MS_DIV=10.
// Revision: 1.0
`default_nettype none

module tb_ms_timer_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic        cfg_cancel = 1'b0;
    logic [1:0]  cfg_ch = 2'd0;
    logic [15:0] cfg_ms = 16'd0;
    logic        cfg_periodic = 1'b0;
    logic [3:0]  irq_clr = 4'd0;
    logic        ms_tick;
    logic [3:0]  busy;
    logic [3:0]  expired;
    logic [3:0]  irq;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    ms_timer_scheduler #(
        .MS_DIV (10),
        .NUM_CH (4),
        .CNT_W  (16),
        .CH_W   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_we       (cfg_we),
        .cfg_cancel   (cfg_cancel),
        .cfg_ch       (cfg_ch),
        .cfg_ms       (cfg_ms),
`ifdef MS_TIMER_SCHED_PERIODIC_EN
        .cfg_periodic (cfg_periodic),
`endif
        .irq_clr      (irq_clr),
        .ms_tick      (ms_tick),
        .busy         (busy),
        .expired      (expired),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          e;
        logic        we;
        logic        cancel;
        logic [1:0]  ch;
        logic [15:0] ms;
        logic [3:0]  clr;
        logic [3:0]  busy;
        logic [3:0]  expd;
        logic [3:0]  irq;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int e, input logic we, input logic cancel, input logic [1:0] ch,
                       input logic [15:0] ms, input logic [3:0] clr, input logic [3:0] b,
                       input logic [3:0] x, input logic [3:0] q);
        vec_t v;
        v.e = e; v.we = we; v.cancel = cancel; v.ch = ch; v.ms = ms; v.clr = clr;
        v.busy = b; v.expd = x; v.irq = q;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic idle_inputs();
        cfg_we = 1'b0; cfg_cancel = 1'b0; cfg_ch = 2'd0; cfg_ms = 16'd0;
        cfg_periodic = 1'b0; irq_clr = 4'd0;
    endtask

    initial begin
        int exp_edges[$];
        int n_exp;

        // Edge numbers count posedges after reset release; ticks are visible after edges 10, 20, ...
        //   e    we    can   ch    ms      clr      busy     exp      irq
        add(9,   1'b0, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(10,  1'b0, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(11,  1'b1, 1'b0, 2'd0, 16'd3, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        add(20,  1'b0, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        add(40,  1'b0, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        add(41,  1'b0, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
        add(42,  1'b0, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(45,  1'b0, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(46,  1'b1, 1'b0, 2'd1, 16'd5, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
        add(47,  1'b1, 1'b0, 2'd2, 16'd5, 4'b0000, 4'b0110, 4'b0000, 4'b0000);
        add(48,  1'b1, 1'b0, 2'd3, 16'd7, 4'b0000, 4'b1110, 4'b0000, 4'b0000);
        add(60,  1'b0, 1'b1, 2'd3, 16'd0, 4'b0000, 4'b0110, 4'b0000, 4'b0000);
        add(90,  1'b0, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0110, 4'b0000, 4'b0000);
        add(91,  1'b0, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000, 4'b0110, 4'b0110);
        add(92,  1'b0, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0110);
        add(95,  1'b0, 1'b0, 2'd0, 16'd0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        add(96,  1'b1, 1'b0, 2'd0, 16'd2, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        add(111, 1'b1, 1'b0, 2'd0, 16'd4, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        add(150, 1'b0, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        add(151, 1'b0, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
        add(153, 1'b1, 1'b0, 2'd2, 16'd0, 4'b0000, 4'b0000, 4'b0100, 4'b0101);
        add(154, 1'b0, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0101);
        add(155, 1'b1, 1'b1, 2'd1, 16'd3, 4'b0000, 4'b0010, 4'b0000, 4'b0101);
        add(156, 1'b0, 1'b1, 2'd1, 16'd0, 4'b0101, 4'b0000, 4'b0000, 4'b0000);
        add(157, 1'b1, 1'b0, 2'd3, 16'd1, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
        add(161, 1'b0, 1'b0, 2'd0, 16'd0, 4'b1000, 4'b0000, 4'b1000, 4'b1000);

        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_tick", 32'(ms_tick), 32'd0);
        rst = 1'b0;
        edge_n = 0;

        foreach (vecs[i]) begin
            while (edge_n < vecs[i].e - 1) step();
            cfg_we = vecs[i].we; cfg_cancel = vecs[i].cancel; cfg_ch = vecs[i].ch;
            cfg_ms = vecs[i].ms; irq_clr = vecs[i].clr;
            step();
            idle_inputs();
            check("ms_tick", 32'(ms_tick), 32'((vecs[i].e % 10) == 0));
            check("busy", 32'(busy), 32'(vecs[i].busy));
            check("expired", 32'(expired), 32'(vecs[i].expd));
            check("irq", 32'(irq), 32'(vecs[i].irq));
        end

        // Periodic sequence: ch0, 2 ms, periodic requested.
        irq_clr = 4'b1111;
        step();
        idle_inputs();
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_ms = 16'd2; cfg_periodic = 1'b1;
        step();
        idle_inputs();
        for (int k = 0; k < 120; k++) begin
            step();
            if (expired[0]) exp_edges.push_back(edge_n);
        end
        n_exp = exp_edges.size();
`ifdef MS_TIMER_SCHED_PERIODIC_EN
        check("periodic_count", 32'(n_exp >= 5), 32'd1);
        for (int k = 1; k < n_exp; k++)
            check("periodic_interval", 32'(exp_edges[k] - exp_edges[k-1]), 32'd20);
        check("periodic_busy", 32'(busy[0]), 32'd1);
        cfg_cancel = 1'b1; cfg_ch = 2'd0;
        step();
        idle_inputs();
        check("periodic_cancel_busy", 32'(busy[0]), 32'd0);
        n_exp = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (expired[0]) n_exp++;
        end
        check("periodic_after_cancel", 32'(n_exp), 32'd0);
`else
        check("oneshot_count", 32'(n_exp), 32'd1);
        check("oneshot_busy", 32'(busy[0]), 32'd0);
`endif

        // Asynchronous reset in the middle of a run, between clock edges.
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_ms = 16'd2;
        step();
        idle_inputs();
        step();
        check("pre_async_busy", 32'(busy[1]), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_irq", 32'(irq), 32'd0);
        check("async_expired", 32'(expired), 32'd0);
        check("async_tick", 32'(ms_tick), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        edge_n = 0;
        n_exp = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (expired != 4'd0 || busy != 4'd0) n_exp++;
            if (edge_n == 10) check("post_reset_tick", 32'(ms_tick), 32'd1);
        end
        check("post_reset_quiet", 32'(n_exp), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
